// File: rtl/mem_responder_pkg.sv
// Shared address map and timer encodings for the data-side memory responder.
// Imported by the responder RTL and by processor-side test code.
package mem_responder_pkg;

  localparam logic [3:0] PG_RAM   = 4'h0;
  localparam logic [3:0] PG_LED   = 4'h1;
  localparam logic [3:0] PG_SW    = 4'h3;
  localparam logic [3:0] PG_TCNT  = 4'h4;
  localparam logic [3:0] PG_TCMP  = 4'h5;
  localparam logic [3:0] PG_TSTAT = 4'h6;
  localparam logic [3:0] PG_TCTL  = 4'h7;

  localparam int CTL_EN = 0;
  localparam int CTL_AR = 1;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/mr_timer.sv
// Compare timer: free-running 16-bit count, compare match sets a sticky status
// flag that is cleared by reading it. The FSM state mirrors control bit 0.
module mr_timer
  import mem_responder_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        wr_cnt,
  input  logic        wr_cmp,
  input  logic        wr_ctl,
  input  logic        rd_clr,
  input  logic [15:0] wdata,
  output logic [15:0] count,
  output logic [15:0] compare,
  output logic [1:0]  control,
  output logic        status,
  output tmr_state_t  state
);

  tmr_state_t  state_q, state_d;
  logic        auto_q, auto_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cmp_q, cmp_d;
  logic        stat_q, stat_d;
  logic        hit;

  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    if (wr_ctl) begin
      state_d = wdata[CTL_EN] ? TMR_RUN : TMR_IDLE;
      auto_d  = wdata[CTL_AR];
    end

    // Match uses the registered compare, so a compare write takes effect next cycle.
    hit = (state_q == TMR_RUN) && (cnt_q == cmp_q);

    cnt_d = cnt_q;
    if (wr_cnt) begin
      cnt_d = wdata;
    end else if (state_q == TMR_RUN) begin
      cnt_d = (hit && auto_q) ? 16'h0000 : cnt_q + 16'd1;
    end

    cmp_d = wr_cmp ? wdata : cmp_q;

    // A set on the same edge as a clearing read wins.
    stat_d = stat_q;
    if (hit) begin
      stat_d = 1'b1;
    end else if (rd_clr) begin
      stat_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= TMR_IDLE;
      auto_q  <= 1'b0;
      cnt_q   <= 16'h0000;
      cmp_q   <= 16'hFFFF;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      stat_q  <= stat_d;
    end
  end

  assign count   = cnt_q;
  assign compare = cmp_q;
  assign control = {auto_q, (state_q == TMR_RUN)};
  assign status  = stat_q;
  assign state   = state_q;

endmodule

// File: rtl/mem_responder.sv
// Data-side memory responder: RAM, LED register, synchronised switches and a
// compare timer behind a page decoder on ADDR[15:12], with 1-cycle read data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int SW_WIDTH  = 10,
  parameter int LED_WIDTH = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [15:0]          ADDR,
  input  logic [15:0]          DOUT,
  input  logic                 W,
  input  logic [SW_WIDTH-1:0]  SW,
  output logic [15:0]          DIN,
  output logic [LED_WIDTH-1:0] LEDR,
  output logic                 IRQ
);

  localparam int AW = $clog2(RAM_WORDS);

  // Bus protocol: no strobes or handshake. Every cycle reads ADDR and returns
  // its value on DIN after the next edge; W=1 writes DOUT on that same edge,
  // and the read returns the value from before the write.

  logic [3:0]           page;
  logic [AW-1:0]        idx;
  logic [15:0]          mem [RAM_WORDS];
  logic [15:0]          ram_rd_q;
  logic                 ram_sel_q;
  logic [15:0]          reg_rd, reg_rd_q;
  logic [LED_WIDTH-1:0] led_q;
  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  logic                 ram_we;
  logic [15:0]          t_count, t_compare;
  logic [1:0]           t_control;
  logic                 t_status;
  tmr_state_t           t_state;
  logic                 unused_bits;

  assign page   = ADDR[15:12];
  assign idx    = ADDR[AW-1:0];
  assign ram_we = W && !Reset && (page == PG_RAM);

  mr_timer u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_cnt  (W && (page == PG_TCNT)),
    .wr_cmp  (W && (page == PG_TCMP)),
    .wr_ctl  (W && (page == PG_TCTL)),
    .rd_clr  (page == PG_TSTAT),
    .wdata   (DOUT),
    .count   (t_count),
    .compare (t_compare),
    .control (t_control),
    .status  (t_status),
    .state   (t_state)
  );

  // Single-port synchronous array with read-first output register.
  always_ff @(posedge Clock) begin
    if (ram_we) begin
      mem[idx] <= DOUT;
    end
    ram_rd_q <= mem[idx];
  end

  always_comb begin
    reg_rd = 16'h0000;
    case (page)
      PG_LED:   reg_rd[LED_WIDTH-1:0] = led_q;
      PG_SW:    reg_rd[SW_WIDTH-1:0]  = sw_s2;
      PG_TCNT:  reg_rd = t_count;
      PG_TCMP:  reg_rd = t_compare;
      PG_TSTAT: reg_rd[0] = t_status;
      PG_TCTL:  reg_rd[1:0] = t_control;
      default:  reg_rd = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      led_q     <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      ram_sel_q <= 1'b0;
      reg_rd_q  <= 16'h0000;
    end else begin
      if (W && (page == PG_LED)) begin
        led_q <= DOUT[LED_WIDTH-1:0];
      end
      sw_s1     <= SW;
      sw_s2     <= sw_s1;
      ram_sel_q <= (page == PG_RAM);
      reg_rd_q  <= reg_rd;
    end
  end

  assign DIN  = ram_sel_q ? ram_rd_q : reg_rd_q;
  assign LEDR = led_q;
  assign IRQ  = t_status;

  // Aliased address bits and the timer state are intentionally not consumed.
  assign unused_bits = ^{ADDR[11:0], t_state};

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table for the memory map plus
// hand-written timer, synchroniser and reset sequences.
module tb_mem_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [9:0]  SW;
  logic [15:0] DIN;
  logic [9:0]  LEDR;
  logic        IRQ;

  int n_tests;
  int n_fail;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  mem_responder dut (
    .Clock (Clock),
    .Reset (Reset),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .W     (W),
    .SW    (SW),
    .DIN   (DIN),
    .LEDR  (LEDR),
    .IRQ   (IRQ)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, then sample 1 time unit after the edge.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w);
    ADDR = a;
    DOUT = d;
    W    = w;
    @(posedge Clock);
    #1;
    W = 1'b0;
  endtask

  // Drive one cycle whose read result is scoreboarded.
  task automatic step_chk(input string name, input logic [15:0] a, input logic [15:0] d,
                          input logic w, input logic [15:0] exp);
    logic [15:0] e;
    exp_q.push_back(exp);
    step(a, d, w);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0x%04h", name, DIN);
    end else begin
      e = exp_q.pop_front();
      check(name, DIN, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset = 1'b1;
    ADDR  = 16'h0000;
    DOUT  = 16'h0000;
    W     = 1'b0;
    SW    = 10'h000;

    vecs[0]  = '{16'h0012, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{16'h0012, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vecs[2]  = '{16'h0012, 16'hAAAA, 1'b1, 1'b1, 16'hBEEF};
    vecs[3]  = '{16'h0F12, 16'h0000, 1'b0, 1'b1, 16'hAAAA};
    vecs[4]  = '{16'h1000, 16'h03FF, 1'b1, 1'b1, 16'h0000};
    vecs[5]  = '{16'h1000, 16'h0000, 1'b0, 1'b1, 16'h03FF};
    vecs[6]  = '{16'h1FFF, 16'h0000, 1'b0, 1'b1, 16'h03FF};
    vecs[7]  = '{16'hA012, 16'h1234, 1'b1, 1'b1, 16'h0000};
    vecs[8]  = '{16'hA000, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[9]  = '{16'h0012, 16'h0000, 1'b0, 1'b1, 16'hAAAA};
    vecs[10] = '{16'h2000, 16'h5555, 1'b1, 1'b1, 16'h0000};
    vecs[11] = '{16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0000};

    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;

    check("reset_din", DIN, 16'h0000);
    check("reset_ledr", {6'h00, LEDR}, 16'h0000);
    check("reset_irq", {15'h0000, IRQ}, 16'h0000);
    step_chk("reset_compare", 16'h5000, 16'h0000, 1'b0, 16'hFFFF);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].chk) begin
        step_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dout, vecs[i].w, vecs[i].exp);
      end else begin
        step(vecs[i].addr, vecs[i].dout, vecs[i].w);
      end
    end
    check("ledr_value", {6'h00, LEDR}, 16'h03FF);

    // Switch synchroniser, with an ignored write to the switch page.
    SW = 10'h155;
    step_chk("sw_edge1", 16'h3000, 16'hFFFF, 1'b1, 16'h0000);
    step_chk("sw_edge2", 16'h3000, 16'h0000, 1'b0, 16'h0000);
    step_chk("sw_edge3", 16'h3000, 16'h0000, 1'b0, 16'h0155);

    // Timer auto-reload: compare=4, enable with auto-reload.
    step(16'h5000, 16'h0004, 1'b1);
    step(16'h7000, 16'h0003, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step_chk($sformatf("tcnt_%0d", k), 16'h4000, 16'h0000, 1'b0, 16'(k - 1));
      check($sformatf("irq_%0d", k), {15'h0000, IRQ}, (k == 5) ? 16'h0001 : 16'h0000);
    end
    step_chk("tcnt_reload", 16'h4000, 16'h0000, 1'b0, 16'h0000);
    step_chk("tstat_read", 16'h6000, 16'h0000, 1'b0, 16'h0001);
    check("irq_cleared", {15'h0000, IRQ}, 16'h0000);

    // Count write on the cycle the count would reach compare suppresses the set.
    step_chk("tcnt_pre", 16'h4000, 16'h0000, 1'b0, 16'h0002);
    step_chk("tcnt_write", 16'h4000, 16'h0010, 1'b1, 16'h0003);
    step_chk("tstat_suppressed", 16'h6000, 16'h0000, 1'b0, 16'h0000);
    check("irq_suppressed", {15'h0000, IRQ}, 16'h0000);

    // Status read on the cycle status sets: read returns 0, set wins.
    step(16'h5000, 16'h0020, 1'b1);
    repeat (14) step(16'h4000, 16'h0000, 1'b0);
    step_chk("tstat_coincide", 16'h6000, 16'h0000, 1'b0, 16'h0000);
    check("irq_coincide", {15'h0000, IRQ}, 16'h0001);
    step_chk("tstat_after", 16'h6000, 16'h0000, 1'b0, 16'h0001);
    check("irq_after", {15'h0000, IRQ}, 16'h0000);

    // Raise status again, then reset while running with a concurrent LED write.
    step(16'h5000, 16'h0003, 1'b1);
    step(16'h0000, 16'h0000, 1'b0);
    step(16'h0000, 16'h0000, 1'b0);
    check("irq_before_reset", {15'h0000, IRQ}, 16'h0001);
    Reset = 1'b1;
    step(16'h1000, 16'h02AA, 1'b1);
    Reset = 1'b0;
    check("reset_mid_irq", {15'h0000, IRQ}, 16'h0000);
    check("reset_mid_ledr", {6'h00, LEDR}, 16'h0000);
    check("reset_mid_din", DIN, 16'h0000);
    step_chk("reset_mid_tctl", 16'h7000, 16'h0000, 1'b0, 16'h0000);
    step_chk("reset_mid_tcnt", 16'h4000, 16'h0000, 1'b0, 16'h0000);
    step_chk("reset_mid_tcnt_idle", 16'h4000, 16'h0000, 1'b0, 16'h0000);
    step_chk("reset_mid_tstat", 16'h6000, 16'h0000, 1'b0, 16'h0000);
    step_chk("reset_mid_tcmp", 16'h5000, 16'h0000, 1'b0, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
